dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The parameter WAIT_CYCLES SHALL default to 0 and set the extra stall cycles per access; legal range is 0..15.
REQ-002 The port list SHALL contain the following ports, clock and reset first.
- clk  input  1  single clock for the whole block.
- rst_n  input  1  asynchronous, active-low reset.
- mem_read_M  input  1  pipeline load request.
- mem_write_M  input  1  pipeline store request.
- alu_out_M  input  32  byte address of the access.
- write_data_M  input  32  store data.
- read_data_M  output  32  load data returned to the pipeline.
- data_mem_ack_M  output  1  one-cycle access-complete acknowledge.
- mem_fault_M  output  1  access fault, valid with the acknowledge.
- ram_wr_en  output  1  RAM write enable.
- ram_addr  output  8  RAM word address.
- ram_data_in  output  32  RAM write data.
- ram_mem_out  input  32  RAM registered read data, valid one cycle after the address.

Function
REQ-003 The block SHALL implement the states IDLE, ACCESS, WAIT and ACK.
REQ-004 In IDLE, a cycle with mem_read_M or mem_write_M high SHALL latch the address, write data and operation at the clock edge and go to ACCESS.
REQ-005 When both mem_read_M and mem_write_M are high, the block SHALL perform a write.
REQ-006 The block SHALL ignore changes on the request inputs after acceptance until it returns to IDLE.
REQ-007 ram_addr SHALL equal latched address bits [9:2] in ACCESS, WAIT and ACK, and SHALL hold its last value in IDLE.
REQ-008 ram_data_in SHALL equal the latched write data.
REQ-009 ram_wr_en SHALL be high only in ACCESS for a write, for exactly one cycle.
REQ-010 A read SHALL spend WAIT_CYCLES+1 cycles in WAIT; a write SHALL spend WAIT_CYCLES cycles in WAIT and skip WAIT when WAIT_CYCLES is 0.
REQ-011 The WAIT cycle count SHALL come from a 5-bit down-counter loaded on leaving ACCESS.
REQ-012 On the WAIT-to-ACK transition of a read, read_data_M SHALL register ram_mem_out.
REQ-013 read_data_M SHALL hold its value until the next read capture; writes SHALL leave it unchanged.
REQ-014 data_mem_ack_M SHALL be registered and high only in ACK, for exactly one cycle; ACK SHALL always go to IDLE.
REQ-015 With the request accepted in cycle T, read acknowledge latency SHALL be T+3+WAIT_CYCLES and write acknowledge latency SHALL be T+2+WAIT_CYCLES.
REQ-016 A request still high during ACK SHALL NOT be accepted; the earliest next acceptance SHALL be the cycle after ACK.

Reset
REQ-017 Asserting rst_n low at any time, including mid-access, SHALL asynchronously force IDLE.
REQ-018 During reset, ram_wr_en, data_mem_ack_M, mem_fault_M, the wait counter, read_data_M, ram_addr and ram_data_in SHALL all be 0.
REQ-019 An access interrupted by reset SHALL be abandoned with no acknowledge; a write interrupted in ACCESS MAY have completed in the RAM.

Configuration
REQ-020 When DMEM_FAULT_CHECK_EN is defined, a request with alu_out_M[1:0] nonzero or alu_out_M[31:10] nonzero SHALL go IDLE to ACK directly.
REQ-021 A faulting request SHALL make no RAM write, SHALL assert mem_fault_M with data_mem_ack_M, and SHALL leave read_data_M unchanged.
REQ-022 When DMEM_FAULT_CHECK_EN is undefined, mem_fault_M SHALL be tied to 0 and address bits [1:0] and [31:10] SHALL be ignored.

Structure
REQ-023 The shared package dmem_pkg SHALL hold the state enum, DMEM_ADDR_BITS=8, DMEM_DATA_WIDTH=32 and the wait-counter width.
REQ-024 The block SHALL have no sub-module; the RAM SHALL be instantiated by the parent.

Verification
REQ-025 The bench SHALL cover a write then a read with WAIT_CYCLES=0: write 0xDEADBEEF to 0x0000_0010, then read 0x10; write ack at T+2, read ack at T+3 with 0xDEADBEEF, and ram_addr 0x04.
REQ-026 The bench SHALL cover WAIT_CYCLES=3: a read of 0x0000_03FC acks at T+6 with the stored word; a write acks at T+5.
REQ-027 The bench SHALL cover requests held high across ACK, back to back: the second access is accepted the cycle after ACK, with exactly one ack pulse per access.
REQ-028 The bench SHALL cover rst_n low during WAIT of a read: IDLE and all outputs 0 immediately, no ack afterwards, and the next request serviced normally.
REQ-029 The bench SHALL cover, with DMEM_FAULT_CHECK_EN defined, a write to 0x0000_0402 and a read of 0x0000_0001: both ack at T+1 with mem_fault_M=1, no ram_wr_en pulse, and read_data_M unchanged.
REQ-030 The bench SHALL cover mem_read_M and mem_write_M both high: a write is performed, and a subsequent read returns write_data_M.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared types and sizes for the data-memory access controller.
//             Holds the controller state encoding, the RAM word-address and
//             data widths, the wait-counter width, and the address-fault
//             helper used when DMEM_FAULT_CHECK_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

  localparam int DMEM_ADDR_BITS  = 8;
  localparam int DMEM_DATA_WIDTH = 32;
  // Wide enough to hold WAIT_CYCLES+1 for the largest legal WAIT_CYCLES (15).
  localparam int DMEM_WAIT_CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } dmem_state_e;

  // An address faults when it is not word aligned or lies beyond the
  // 1 KiB window covered by the RAM.
  function automatic logic dmem_addr_fault(input logic [DMEM_DATA_WIDTH-1:0] addr);
    return (|addr[1:0]) | (|addr[DMEM_DATA_WIDTH-1:DMEM_ADDR_BITS+2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_ctrl
//  Purpose  : Single-access data-memory controller between the pipeline M
//             stage and a synchronous RAM with registered read data.
//             Accepts one load/store in IDLE, drives the RAM, stalls for
//             WAIT_CYCLES extra cycles and returns a one-cycle acknowledge.
//  Config   : DMEM_FAULT_CHECK_EN -- when defined, misaligned or out-of-range
//             addresses are acknowledged at once with mem_fault_M and never
//             touch the RAM. When undefined, mem_fault_M is 0.
//  Ports    :
//    clk             in   clock
//    rst_n           in   asynchronous active-low reset
//    mem_read_M      in   load request
//    mem_write_M     in   store request (wins over load if both high)
//    alu_out_M       in   [31:0] byte address
//    write_data_M    in   [31:0] store data
//    read_data_M     out  [31:0] load data, held until the next load
//    data_mem_ack_M  out  one-cycle access-complete pulse
//    mem_fault_M     out  access fault, valid with the acknowledge
//    ram_wr_en       out  RAM write enable
//    ram_addr        out  [7:0] RAM word address
//    ram_data_in     out  [31:0] RAM write data
//    ram_mem_out     in   [31:0] RAM read data, one cycle after address
//  Revision : 1.0  initial release
// ============================================================================
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mem_read_M,
  input  logic                       mem_write_M,
  input  logic [DMEM_DATA_WIDTH-1:0] alu_out_M,
  input  logic [DMEM_DATA_WIDTH-1:0] write_data_M,
  output logic [DMEM_DATA_WIDTH-1:0] read_data_M,
  output logic                       data_mem_ack_M,
  output logic                       mem_fault_M,
  output logic                       ram_wr_en,
  output logic [DMEM_ADDR_BITS-1:0]  ram_addr,
  output logic [DMEM_DATA_WIDTH-1:0] ram_data_in,
  input  logic [DMEM_DATA_WIDTH-1:0] ram_mem_out
);

  // A read needs one more WAIT cycle than a write because the RAM output
  // only becomes valid the cycle after the address is presented.
  localparam logic [DMEM_WAIT_CNT_W-1:0] c_rd_wait = DMEM_WAIT_CNT_W'(WAIT_CYCLES + 1);
  localparam logic [DMEM_WAIT_CNT_W-1:0] c_wr_wait = DMEM_WAIT_CNT_W'(WAIT_CYCLES);

  dmem_state_e                r_state;
  logic                       r_is_write;
  logic [DMEM_WAIT_CNT_W-1:0] r_wait_cnt;
  logic                       r_fault;
  logic                       w_req;
  logic                       w_fault;

  assign w_req = mem_read_M | mem_write_M;

`ifdef DMEM_FAULT_CHECK_EN
  assign w_fault     = dmem_addr_fault(alu_out_M);
  assign mem_fault_M = r_fault;
`else
  // Address bits outside the word index are don't-care in this build.
  logic w_unused_addr;
  assign w_unused_addr = ^{alu_out_M[DMEM_DATA_WIDTH-1:DMEM_ADDR_BITS+2],
                           alu_out_M[1:0], r_fault};
  assign w_fault     = 1'b0;
  assign mem_fault_M = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_is_write     <= 1'b0;
      r_wait_cnt     <= '0;
      r_fault        <= 1'b0;
      read_data_M    <= '0;
      data_mem_ack_M <= 1'b0;
      ram_wr_en      <= 1'b0;
      ram_addr       <= '0;
      ram_data_in    <= '0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle.
      ram_wr_en      <= 1'b0;
      data_mem_ack_M <= 1'b0;
      r_fault        <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            ram_addr    <= alu_out_M[DMEM_ADDR_BITS+1:2];
            ram_data_in <= write_data_M;
            r_is_write  <= mem_write_M;
            if (w_fault) begin
              // Faulting access skips the RAM entirely.
              r_state        <= S_ACK;
              data_mem_ack_M <= 1'b1;
              r_fault        <= 1'b1;
            end else begin
              r_state   <= S_ACCESS;
              ram_wr_en <= mem_write_M;
            end
          end
        end

        S_ACCESS: begin
          if (!r_is_write) begin
            r_wait_cnt <= c_rd_wait;
            r_state    <= S_WAIT;
          end else if (c_wr_wait == '0) begin
            r_wait_cnt     <= '0;
            r_state        <= S_ACK;
            data_mem_ack_M <= 1'b1;
          end else begin
            r_wait_cnt <= c_wr_wait;
            r_state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - DMEM_WAIT_CNT_W'(1);
          if (r_wait_cnt == DMEM_WAIT_CNT_W'(1)) begin
            r_state        <= S_ACK;
            data_mem_ack_M <= 1'b1;
            if (!r_is_write) begin
              read_data_M <= ram_mem_out;
            end
          end
        end

        S_ACK: begin
          // Requests seen here are deliberately ignored; acceptance resumes
          // in IDLE on the following cycle.
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
